// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package sseg_pkg;

    // Width of the value shown on the 4-digit display.
    localparam int unsigned DISP_VAL_W = 16;

    // Display driver mode encoding.
    localparam logic MODE_HEX = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Arbiter FSM: IDLE has no grant, SHOW has exactly one grant.
    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } disp_state_t;

endpackage

// File: rtl/sseg_disp_arbiter_if.sv
// Request/display bus between the datapath sources and the display arbiter.
interface sseg_disp_arbiter_if
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned VAL_W   = DISP_VAL_W
);

    logic [NUM_REQ-1:0]       REQ;
    logic [NUM_REQ*VAL_W-1:0] VALS;
    logic [NUM_REQ-1:0]       MODES;
    logic [NUM_REQ-1:0]       GNT;
    logic [VAL_W-1:0]         DISP_VAL;
    logic                     DISP_MODE;
    logic                     HOLD_DONE;

    // Requester side: presents requests and values, observes the grant.
    modport master (
        output REQ, VALS, MODES,
        input  GNT, DISP_VAL, DISP_MODE, HOLD_DONE
    );

    // Arbiter side.
    modport slave (
        input  REQ, VALS, MODES,
        output GNT, DISP_VAL, DISP_MODE, HOLD_DONE
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_oh,
    output logic [IDX_W-1:0]   win_idx
);

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        logic        found;
        int unsigned cand;
        found   = 1'b0;
        cand    = 0;
        win_oh  = '0;
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/sseg_disp_arbiter.sv
// Round-robin sharing of the 4-digit seven-segment display with a minimum hold
// time per grant. DISP_VAL/DISP_MODE feed the display driver's ALU_VAL/MODE.
module sseg_disp_arbiter
    import sseg_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned VAL_W       = DISP_VAL_W
) (
    input logic                CLK,
    input logic                RST,
    sseg_disp_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // HOLD_CYCLES=1 still needs a 1-bit counter that sits at zero.
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

    disp_state_t        state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic               mode_q, mode_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               hold_done;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == int'(NUM_REQ) - 1) ? '0 : idx + 1'b1;
    endfunction

    // While showing, ptr_q is always granted index + 1, so the same arbiter
    // serves both the IDLE pick and the "next after current" rotation pick.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req     (bus.REQ),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign hold_done = (state_q == SHOW) && (cnt_q == CNT_MAX);

    // Next-state: grant, rotation, release and live value tracking.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        mode_d    = mode_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.REQ) begin
                    state_d   = SHOW;
                    gnt_d     = win_oh;
                    gnt_idx_d = win_idx;
                    ptr_d     = idx_inc(win_idx);
                    cnt_d     = '0;
                    val_d     = bus.VALS[int'(win_idx)*VAL_W +: VAL_W];
                    mode_d    = bus.MODES[win_idx];
                end
            end
            SHOW: begin
                if (!bus.REQ[gnt_idx_q]) begin
                    // Release beats rotation; display keeps its last value.
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = idx_inc(gnt_idx_q);
                    cnt_d   = '0;
                end else if (hold_done && (win_idx != gnt_idx_q)) begin
                    gnt_d     = win_oh;
                    gnt_idx_d = win_idx;
                    ptr_d     = idx_inc(win_idx);
                    cnt_d     = '0;
                    val_d     = bus.VALS[int'(win_idx)*VAL_W +: VAL_W];
                    mode_d    = bus.MODES[win_idx];
                end else begin
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    val_d  = bus.VALS[int'(gnt_idx_q)*VAL_W +: VAL_W];
                    mode_d = bus.MODES[gnt_idx_q];
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            val_q     <= '0;
            mode_q    <= MODE_HEX;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            val_q     <= val_d;
            mode_q    <= mode_d;
        end
    end

    assign bus.GNT       = gnt_q;
    assign bus.DISP_VAL  = val_q;
    assign bus.DISP_MODE = mode_q;
    assign bus.HOLD_DONE = hold_done;

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Directed bench for the display arbiter, NUM_REQ=4, HOLD_CYCLES=4.
module tb_sseg_disp_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    sseg_disp_arbiter_if #(.NUM_REQ(4), .VAL_W(16)) bus ();

    sseg_disp_arbiter #(
        .NUM_REQ     (4),
        .HOLD_CYCLES (4),
        .VAL_W       (16)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [63:0] vals;
        logic [3:0]  modes;
        logic [3:0]  gnt;
        logic [15:0] val;
        logic        mode;
        logic        hd;
    } vec_t;

    vec_t rr_tab [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] gnt, input logic [15:0] val,
                             input logic mode, input logic hd);
        check({name, " gnt"}, 32'(bus.GNT), 32'(gnt));
        check({name, " val"}, 32'(bus.DISP_VAL), 32'(val));
        check({name, " mode"}, 32'(bus.DISP_MODE), 32'(mode));
        check({name, " hold_done"}, 32'(bus.HOLD_DONE), 32'(hd));
        check({name, " onehot"}, 32'($countones(bus.GNT) > 1), 32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse between edges with all requests dropped.
    task automatic do_reset();
        bus.REQ   = 4'b0000;
        bus.VALS  = '0;
        bus.MODES = 4'b0000;
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Round-robin table: REQ=0101 from reset, req2 in decimal mode.
        rr_tab[0] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0001, 16'h1111, 1'b0, 1'b0};
        rr_tab[1] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0001, 16'h1111, 1'b0, 1'b0};
        rr_tab[2] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0001, 16'h1111, 1'b0, 1'b0};
        rr_tab[3] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0001, 16'h1111, 1'b0, 1'b1};
        rr_tab[4] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0100, 16'h2222, 1'b1, 1'b0};
        rr_tab[5] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0100, 16'h2222, 1'b1, 1'b0};
        rr_tab[6] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0100, 16'h2222, 1'b1, 1'b0};
        rr_tab[7] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0100, 16'h2222, 1'b1, 1'b1};
        rr_tab[8] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0001, 16'h1111, 1'b0, 1'b0};
        rr_tab[9] = '{4'b0101, 64'h0000_2222_0000_1111, 4'b0100, 4'b0001, 16'h1111, 1'b0, 1'b0};

        // 1. Reset, including asynchronous assertion mid-grant.
        bus.REQ   = 4'b1111;
        bus.VALS  = 64'h0000_0000_0000_AAAA;
        bus.MODES = 4'b0000;
        #1;
        check_out("reset", 4'b0000, 16'h0000, 1'b0, 1'b0);
        #6;
        rst = 1'b0;
        step();
        check_out("first grant", 4'b0001, 16'hAAAA, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async reset", 4'b0000, 16'h0000, 1'b0, 1'b0);
        step();
        check_out("reset held", 4'b0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("grant after reset", 4'b0001, 16'hAAAA, 1'b0, 1'b0);

        // 2. Single requester: hold flag on 4th SHOW cycle, grant kept.
        do_reset();
        bus.REQ  = 4'b0010;
        bus.VALS = 64'h0000_0000_1234_0000;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_out($sformatf("single[%0d]", k), 4'b0010, 16'h1234, 1'b0, k >= 4);
        end

        // 3. Round-robin between requesters 0 and 2, no idle gap.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            bus.REQ   = rr_tab[k].req;
            bus.VALS  = rr_tab[k].vals;
            bus.MODES = rr_tab[k].modes;
            step();
            check_out($sformatf("rr[%0d]", k), rr_tab[k].gnt, rr_tab[k].val, rr_tab[k].mode,
                      rr_tab[k].hd);
        end

        // 4. Early release keeps the value; pointer wraps 3 -> 0.
        do_reset();
        bus.REQ  = 4'b0100;
        bus.VALS = 64'h0000_00FF_0000_0F0F;
        step();
        check_out("early grant", 4'b0100, 16'h00FF, 1'b0, 1'b0);
        step();
        bus.REQ = 4'b0000;
        step();
        check_out("early release", 4'b0000, 16'h00FF, 1'b0, 1'b0);
        bus.REQ = 4'b0101;
        step();
        check_out("wrap grant", 4'b0001, 16'h0F0F, 1'b0, 1'b0);

        // 5. Live tracking of value and mode.
        do_reset();
        bus.REQ  = 4'b0001;
        bus.VALS = 64'h0000_0000_0000_0009;
        step();
        check_out("live before", 4'b0001, 16'h0009, 1'b0, 1'b0);
        bus.VALS  = 64'h0000_0000_0000_000A;
        bus.MODES = 4'b0001;
        #1;
        check_out("live no edge", 4'b0001, 16'h0009, 1'b0, 1'b0);
        step();
        check_out("live after", 4'b0001, 16'h000A, 1'b1, 1'b0);

        // 6. Drop coincides with rotation eligibility: drop wins.
        do_reset();
        bus.REQ  = 4'b0011;
        bus.VALS = 64'h0000_0000_0B0B_0A0A;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out($sformatf("drop hold[%0d]", k), 4'b0001, 16'h0A0A, 1'b0, k == 4);
        end
        bus.REQ = 4'b0010;
        step();
        check_out("drop idle", 4'b0000, 16'h0A0A, 1'b0, 1'b0);
        step();
        check_out("drop regrant", 4'b0010, 16'h0B0B, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_disp_arbiter.md
Name: sseg_disp_arbiter

Overview:
- Shares the single 4-digit seven-segment display between up to NUM_REQ requesters, e.g. ALU result, PC, I/O port and debug register.
- Grants the display round-robin, with a minimum on-screen hold time per grant, so every value stays readable.
- Drives the 16-bit value and hex/decimal mode inputs of the display driver (SevSegDisp).
- Sits between the MCU datapath sources and SevSegDisp.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 100_000_000, minimum grant duration in CLK cycles (1 s at 100 MHz). Benches use 4.
- VAL_W, 16, display value width.

Ports:
- CLK  input  1  100 MHz system clock
- RST  input  1  asynchronous, active-high reset
- REQ  input  NUM_REQ  per-requester display request, level-sensitive
- VALS  input  NUM_REQ*VAL_W  packed request values; requester i occupies bits [i*VAL_W +: VAL_W]
- MODES  input  NUM_REQ  per-requester mode: 0 hex, 1 decimal
- GNT  output  NUM_REQ  one-hot grant, registered
- DISP_VAL  output  VAL_W  value to SevSegDisp ALU_VAL, registered
- DISP_MODE  output  1  mode to SevSegDisp MODE, registered
- HOLD_DONE  output  1  high while the current grant's minimum hold has elapsed

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high (RST).
- Reset values:
  - GNT=0, DISP_VAL=0, DISP_MODE=0, HOLD_DONE=0.
  - State IDLE, hold counter 0, priority pointer 0 (requester 0 highest).
  - Reset asserted mid-grant clears everything immediately, with no clock edge needed.
- FSM states: IDLE and SHOW.
- IDLE:
  - If any REQ is high, pick the winner by round-robin from the pointer.
  - On the next edge: GNT = winner one-hot, counter = 0, state = SHOW.
  - Latency REQ to GNT is 1 cycle.
- SHOW:
  - Every cycle DISP_VAL and DISP_MODE register VALS and MODES of the granted index, so they follow live values with 1-cycle latency.
  - Counter increments each cycle and saturates at HOLD_CYCLES-1.
  - HOLD_DONE = (counter == HOLD_CYCLES-1).
- Release, granted REQ drops (any time, including before the hold expires):
  - Next edge: GNT=0, state IDLE, pointer = granted index + 1 (mod NUM_REQ).
  - DISP_VAL and DISP_MODE keep their last value; the display never blanks.
- Rotation: when HOLD_DONE is high and another REQ is high:
  - Next edge: GNT moves to the round-robin winner after the current index, counter = 0, pointer advances.
  - No idle gap cycle between grants.
- Sole requester: when HOLD_DONE is high and no other REQ is high, the grant is kept indefinitely and the counter stays saturated.
- Simultaneous events:
  - Granted REQ drop and rotation eligibility in the same cycle: drop wins, go to IDLE. The IDLE pick happens on the following cycle.
  - Multiple new requests: round-robin order starting at the pointer, wrapping from NUM_REQ-1 to 0.
- Pointer update: the pointer only changes on a grant change.
- Invariants:
  - GNT is never multi-hot.
  - GNT is never nonzero in IDLE.
- Counter width is $clog2(HOLD_CYCLES). HOLD_CYCLES=1 gives HOLD_DONE high on the first SHOW cycle.

Decomposition:
- Package sseg_pkg holds:
  - typedef enum disp_state_t {IDLE, SHOW}
  - localparam DISP_VAL_W=16
  - MODE_HEX=0, MODE_DEC=1 constants
- One sub-module: rr_arbiter.
  - Combinational, parameterized NUM_REQ.
  - Inputs: request vector, pointer.
  - Outputs: one-hot winner and winner index.
- Top-level instantiation connects DISP_VAL to SevSegDisp ALU_VAL and DISP_MODE to MODE.

Test Plan:
All scenarios use NUM_REQ=4 and HOLD_CYCLES=4.
1. Reset: RST pulsed between edges, with REQ=1111 applied -> GNT=0000, DISP_VAL=0x0000, DISP_MODE=0 asynchronously. After release, the first grant is 0001.
2. Single request: REQ=0010, VALS[1]=0x1234, MODES[1]=0 -> GNT=0010 and DISP_VAL=0x1234 one edge later. HOLD_DONE rises on the 4th SHOW cycle. Grant held for 20 cycles with no change.
3. Round-robin from reset: REQ=0101 held -> GNT sequence 0001 (4 cycles), 0100 (4 cycles), 0001, ... with no idle cycles. DISP_VAL switches on the same edge as GNT.
4. Early release: requester 2 granted with VAL 0x00FF; REQ[2] dropped at counter=1 -> GNT=0000 next edge, DISP_VAL stays 0x00FF. A later REQ=0101 grants 0001, because the pointer is 3 and wraps to 0.
5. Live tracking: while granted, VALS[0] steps 0x0009 -> 0x000A and MODES[0] 0 -> 1 -> DISP_VAL=0x000A and DISP_MODE=1 exactly one edge later.
6. Simultaneous drop and rotate: HOLD_DONE high on requester 0, REQ goes from 0011 to 0010 in the same cycle -> GNT=0000 for one cycle, then 0010.
